// File: rtl/phy_pkg.sv
// Shared definitions for the PHY receive path: comma/lock defaults, rx FSM encoding
// and the idle-cycle predicate.
package phy_pkg;

  localparam logic [7:0]  COM_SYMBOL_DEF = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH    = 2'b00,
    LOCKED_H0 = 2'b01,
    LOCKED_H1 = 2'b10
  } rx_state_e;

  // An idle cycle carries the comma byte on both lanes with neither lane valid.
  function automatic logic is_idle(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic v0, input logic v1,
                                   input logic [7:0] com);
    return (!v0 && !v1 && (b0 == com) && (b1 == com));
  endfunction

endpackage

// File: rtl/phy_rx_assembler.sv
// Collects two 16-bit lane pairs into one 32-bit word, MSB half first, and
// registers the word together with a one-cycle valid strobe.
module phy_rx_assembler
  import phy_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cap_hi,
  input  logic        i_cap_lo,
  input  logic [7:0]  i_lane0,
  input  logic [7:0]  i_lane1,
  output logic [31:0] o_data,
  output logic        o_valid
);

  logic [15:0] r_hi;
  logic [31:0] r_data;
  logic        r_valid;

  // High half is held until the matching low half arrives; a stale half is simply overwritten.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= 16'h0000;
    end else if (i_cap_hi) begin
      r_hi <= {i_lane0, i_lane1};
    end else begin
      r_hi <= r_hi;
    end
  end

  // Output word and strobe; the word holds between strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (i_cap_lo) begin
      r_data  <= {r_hi, i_lane0, i_lane1};
      r_valid <= 1'b1;
    end else begin
      r_data  <= r_data;
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/phy_rx_unstripe.sv
// Two-lane byte unstriper: locks on LOCK_COUNT idle comma cycles, then rebuilds 32-bit words.
// Optional saturating error counter port when PHY_RX_ERR_CNT_EN is defined.
module phy_rx_unstripe
  import phy_pkg::*;
#(
  parameter logic [7:0]  COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [7:0]  data_in_0,
  input  logic [7:0]  data_in_1,
  input  logic        valid_in0,
  input  logic        valid_in1,
  output logic [31:0] data_output,
  output logic        valid_out,
  output logic        active,
  output logic        error
`ifdef PHY_RX_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

  rx_state_e  r_state, w_state_nxt;
  logic [3:0] r_lock_cnt, w_lock_cnt_nxt;
  logic       r_active, w_active_nxt;
  logic       r_error;
  logic       w_violation, w_cap_hi, w_cap_lo, w_idle, w_both_valid;
  logic [3:0] w_cnt_inc;

  assign w_idle       = is_idle(data_in_0, data_in_1, valid_in0, valid_in1, COM_SYMBOL);
  assign w_both_valid = valid_in0 && valid_in1;
  assign w_cnt_inc    = r_lock_cnt + 4'd1;

  // State, lock counter, active and error registers.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_state    <= SEARCH;
      r_lock_cnt <= 4'd0;
      r_active   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_active   <= w_active_nxt;
      r_error    <= w_violation;
    end
  end

  // Next-state decode; any violation in a locked state drops straight back to SEARCH.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_active_nxt   = r_active;
    w_violation    = 1'b0;
    w_cap_hi       = 1'b0;
    w_cap_lo       = 1'b0;
    case (r_state)
      SEARCH: begin
        w_active_nxt = 1'b0;
        if (w_idle) begin
          if (w_cnt_inc == LOCK_TGT) begin
            w_state_nxt    = LOCKED_H0;
            w_lock_cnt_nxt = 4'd0;
            w_active_nxt   = 1'b1;
          end else begin
            w_lock_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_lock_cnt_nxt = 4'd0;
        end
      end
      LOCKED_H0: begin
        if (w_both_valid) begin
          w_cap_hi    = 1'b1;
          w_state_nxt = LOCKED_H1;
        end else if (w_idle) begin
          w_state_nxt = LOCKED_H0;
        end else begin
          w_violation = 1'b1;
        end
      end
      LOCKED_H1: begin
        // An idle between halves is illegal: the half word is abandoned.
        if (w_both_valid) begin
          w_cap_lo    = 1'b1;
          w_state_nxt = LOCKED_H0;
        end else begin
          w_violation = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = SEARCH;
        w_lock_cnt_nxt = 4'd0;
        w_active_nxt   = 1'b0;
      end
    endcase
    if (w_violation) begin
      w_state_nxt    = SEARCH;
      w_lock_cnt_nxt = 4'd0;
      w_active_nxt   = 1'b0;
    end else begin
      w_active_nxt   = w_active_nxt;
    end
  end

  phy_rx_assembler u_asm (
    .i_clk    (clk_2f),
    .i_rst_n  (reset),
    .i_cap_hi (w_cap_hi),
    .i_cap_lo (w_cap_lo),
    .i_lane0  (data_in_0),
    .i_lane1  (data_in_1),
    .o_data   (data_output),
    .o_valid  (valid_out)
  );

  assign active = r_active;
  assign error  = r_error;

`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of violations, cleared only by reset.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= 8'h00;
    end else if (w_violation && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_phy_rx_unstripe.sv
// Self-checking bench for phy_rx_unstripe: directed vector table, hand sequences
// (error saturation, mid-word reset) and randomized traffic against a queue-based model.
module tb_phy_rx_unstripe;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         LOCK = 4;

  logic        clk_2f = 1'b0;
  logic        reset  = 1'b0;
  logic [7:0]  data_in_0 = COM;
  logic [7:0]  data_in_1 = COM;
  logic        valid_in0 = 1'b0;
  logic        valid_in1 = 1'b0;
  logic [31:0] data_output;
  logic        valid_out, active, error;
`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  phy_rx_unstripe dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .data_in_0   (data_in_0),
    .data_in_1   (data_in_1),
    .valid_in0   (valid_in0),
    .valid_in1   (valid_in1),
    .data_output (data_output),
    .valid_out   (valid_out),
    .active      (active),
    .error       (error)
`ifdef PHY_RX_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: locked flag, idle streak, and a byte queue of the word in progress.
  bit         m_locked;
  int         m_streak;
  logic [7:0] m_q[$];
  logic [31:0] m_data;
  bit         m_valid, m_error;
  int         m_errcnt;

  task automatic model_reset();
    m_locked = 0; m_streak = 0; m_q.delete();
    m_data = 32'h0; m_valid = 0; m_error = 0; m_errcnt = 0;
  endtask

  task automatic model_step(input logic [7:0] a, input logic [7:0] b, input logic va, input logic vb);
    bit idle;
    idle = !va && !vb && a == COM && b == COM;
    m_valid = 0;
    m_error = 0;
    if (!m_locked) begin
      if (idle) begin
        m_streak++;
        if (m_streak == LOCK) begin m_locked = 1; m_streak = 0; end
      end else m_streak = 0;
    end else if (va && vb) begin
      m_q.push_back(a);
      m_q.push_back(b);
      if (m_q.size() == 4) begin
        m_data  = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_valid = 1;
        m_q.delete();
      end
    end else if (!(idle && m_q.size() == 0)) begin
      m_error = 1; m_locked = 0; m_streak = 0; m_q.delete();
      if (m_errcnt < 255) m_errcnt++;
    end
  endtask

  task automatic check_errcnt(input string name);
`ifdef PHY_RX_ERR_CNT_EN
    chk(name, {24'h0, err_count}, m_errcnt);
`endif
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic va, input logic vb);
    data_in_0 = a; data_in_1 = b; valid_in0 = va; valid_in1 = vb;
    model_step(a, b, va, vb);
    @(posedge clk_2f); #1;
    chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
    chk("active",    {31'h0, active},    {31'h0, m_locked});
    chk("error",     {31'h0, error},     {31'h0, m_error});
    chk("data",      data_output,        m_data);
    check_errcnt("err_count");
  endtask

  typedef struct {
    logic [7:0]  d0, d1;
    logic        v0, v1;
    logic        e_valid, e_active, e_error;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic va, input logic vb,
                              input logic ev, input logic eact, input logic eerr, input logic [31:0] ed);
    vec_t v;
    v.d0 = a; v.d1 = b; v.v0 = va; v.v1 = vb;
    v.e_valid = ev; v.e_active = eact; v.e_error = eerr; v.e_data = ed;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Lock, single word, back-to-back words, idle between halves, relock, lane mismatch.
    tbl.push_back(mk(COM, COM, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(8'hFF, 8'hFF, 1, 1, 0, 1, 0, 32'h0));
    tbl.push_back(mk(8'hEE, 8'hEE, 1, 1, 1, 1, 0, 32'hFFFFEEEE));
    tbl.push_back(mk(8'h3F, 8'hE1, 1, 1, 0, 1, 0, 32'hFFFFEEEE));
    tbl.push_back(mk(8'h15, 8'hE6, 1, 1, 1, 1, 0, 32'h3FE115E6));
    tbl.push_back(mk(8'hCC, 8'hEE, 1, 1, 0, 1, 0, 32'h3FE115E6));
    tbl.push_back(mk(8'hEE, 8'hEE, 1, 1, 1, 1, 0, 32'hCCEEEEEE));
    tbl.push_back(mk(8'hAA, 8'hAA, 1, 1, 0, 1, 0, 32'hCCEEEEEE));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 0, 1, 32'hCCEEEEEE));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 0, 0, 32'hCCEEEEEE));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 0, 0, 32'hCCEEEEEE));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 0, 0, 32'hCCEEEEEE));
    tbl.push_back(mk(COM, COM, 0, 0, 0, 1, 0, 32'hCCEEEEEE));
    tbl.push_back(mk(8'h11, 8'h22, 1, 0, 0, 0, 1, 32'hCCEEEEEE));
    tbl.push_back(mk(8'h11, COM, 0, 0, 0, 0, 0, 32'hCCEEEEEE));

    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_2f); #1;
      chk("rst_valid",  {31'h0, valid_out}, 32'h0);
      chk("rst_active", {31'h0, active},    32'h0);
      chk("rst_error",  {31'h0, error},     32'h0);
      chk("rst_data",   data_output,        32'h0);
    end
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      data_in_0 = tbl[i].d0; data_in_1 = tbl[i].d1;
      valid_in0 = tbl[i].v0; valid_in1 = tbl[i].v1;
      model_step(tbl[i].d0, tbl[i].d1, tbl[i].v0, tbl[i].v1);
      @(posedge clk_2f); #1;
      chk($sformatf("tbl%0d_valid", i),  {31'h0, valid_out}, {31'h0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_active", i), {31'h0, active},    {31'h0, tbl[i].e_active});
      chk($sformatf("tbl%0d_error", i),  {31'h0, error},     {31'h0, tbl[i].e_error});
      chk($sformatf("tbl%0d_data", i),   data_output,        tbl[i].e_data);
      check_errcnt($sformatf("tbl%0d_errcnt", i));
    end

    // Repeated single-lane violations with relock; counter must saturate.
    for (int k = 0; k < 300; k++) begin
      for (int j = 0; j < LOCK; j++) step(COM, COM, 0, 0);
      step(8'h5A, COM, 1, 0);
    end
`ifdef PHY_RX_ERR_CNT_EN
    chk("errcnt_saturated", {24'h0, err_count}, 32'h0000_00FF);
`endif

    // Reset between the halves of 12345678.
    for (int j = 0; j < LOCK; j++) step(COM, COM, 0, 0);
    step(8'h12, 8'h34, 1, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_data",   data_output,        32'h0);
    chk("async_rst_active", {31'h0, active},    32'h0);
    chk("async_rst_valid",  {31'h0, valid_out}, 32'h0);
    chk("async_rst_error",  {31'h0, error},     32'h0);
    model_reset();
    @(posedge clk_2f); @(posedge clk_2f); #1;
    reset = 1'b1;
    step(8'h56, 8'h78, 1, 1);
    for (int j = 0; j < LOCK; j++) step(COM, COM, 0, 0);
    step(8'h12, 8'h34, 1, 1);
    step(8'h56, 8'h78, 1, 1);
    chk("fresh_word", data_output, 32'h12345678);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 8)       step(COM, COM, 0, 0);
      else if (r < 17) step(8'($urandom), 8'($urandom), 1, 1);
      else if (r == 17) step(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      else if (r == 18) step(COM, 8'($urandom_range(0, 1) != 0 ? COM : 8'h00), 0, 0);
      else             step(8'($urandom), 8'($urandom), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
